// File: rtl/store_narrower.sv
// store_narrower: narrows a 32-bit register to a byte/half/word store and emits it big-endian,
// one byte per accepted beat, flagging stores whose re-extension would not restore the register.
module store_narrower #(
    parameter int ADDR_W     = 32,
    parameter bit SIGNED_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              lossy,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d, idx_q, idx_d;
    logic              done_q, done_d, err_q, err_d, lossy_q, lossy_d;
    logic              legal, last, lossy_calc;
    logic [1:0]        last_idx;
    logic [31:0]       shifted;
    always_comb begin
        legal      = (size == 2'b00) || (size == 2'b01 && !addr[0]) || (size == 2'b10 && addr[1:0] == 2'b00);
        last_idx   = size_q == 2'b00 ? 2'd0 : size_q == 2'b01 ? 2'd1 : 2'd3;
        last       = mem_ready && idx_q == last_idx;
        // Lossy when the discarded upper bits are not a pure extension of the stored part.
        lossy_calc = size_q == 2'b00 ? data_q[31:8] != {24{SIGNED_CHK && data_q[7]}} :
                     size_q == 2'b01 ? data_q[31:16] != {16{SIGNED_CHK && data_q[15]}} : 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            lossy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            data_q  <= data_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
            lossy_q <= lossy_d;
        end
    end
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        data_d  = data_q;
        size_d  = size_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        lossy_d = lossy_q;
        if (state_q == IDLE) begin
            if (start && legal) begin
                state_d = SEND;
                base_d  = addr;
                data_d  = data;
                size_d  = size;
                idx_d   = 2'd0;
            end
            err_d = start && !legal;
        end else if (mem_ready) begin
            idx_d = idx_q + 2'd1;
            if (last) begin
                state_d = IDLE;
                done_d  = 1'b1;
                lossy_d = lossy_calc;
            end
        end
    end
    always_comb begin
        mem_we    = state_q == SEND;
        busy      = mem_we;
        done      = done_q;
        err       = err_q;
        lossy     = lossy_q;
        // Big-endian: the first beat carries the most significant stored byte.
        shifted   = data_q >> {last_idx - idx_q, 3'b000};
        mem_addr  = mem_we ? base_q + ADDR_W'(idx_q) : '0;
        mem_wdata = mem_we ? shifted[7:0] : 8'h00;
    end
endmodule

// File: tb/tb_store_narrower.sv
// tb_store_narrower: table vectors, hand-written corner sequences and random requests
// checked against a byte-list/re-extension reference model.
module tb_store_narrower;
    logic        clk, reset_n, start, mem_ready;
    logic [1:0]  size;
    logic [31:0] addr, data;
    logic        busy, done, err, lossy, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    int          passed = 0, total = 0;
    logic        last_lossy = 1'b0;

    typedef struct {
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] d;
        int          stalls;
        bit          exp_err;
        bit          exp_lossy;
    } vec_t;
    vec_t tbl[11];

    store_narrower #(.ADDR_W(32), .SIGNED_CHK(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .size(size), .addr(addr), .data(data),
        .busy(busy), .done(done), .err(err), .lossy(lossy), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    function automatic bit m_legal(input logic [1:0] sz, input logic [31:0] a);
        return sz != 2'b11 && (a % (32'd1 << sz)) == 0;
    endfunction

    // Sign-extend the stored low 8<<sz bits back to 32 and see if the register survives.
    function automatic bit m_lossy(input logic [1:0] sz, input logic [31:0] d);
        logic signed [31:0] t;
        int w;
        if (sz >= 2) return 1'b0;
        w = 8 << sz;
        t = d << (32 - w);
        t = t >>> (32 - w);
        return t != d;
    endfunction

    task automatic chk_zero(input string name);
        chk({name, "_flags"}, {27'd0, busy, done, err, lossy, mem_we}, 32'd0);
        chk({name, "_addr"}, mem_addr, 32'd0);
        chk({name, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
    endtask

    task automatic do_req(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input int stalls, input bit rnd, input bit noise,
                          input bit exp_err, input bit exp_lossy);
        int n, k, st, cyc;
        size = sz; addr = a; data = d; start = 1'b1;
        tick();
        start = 1'b0;
        if (exp_err) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_no_beat", {30'd0, mem_we, busy}, 32'd0);
            chk("err_no_done", {31'd0, done}, 32'd0);
            chk("err_lossy_hold", {31'd0, lossy}, {31'd0, last_lossy});
            tick();
            chk("err_clear", {29'd0, err, busy, mem_we}, 32'd0);
            return;
        end
        n = 1 << sz; k = 0; st = 0; cyc = 0;
        while (k < n) begin
            chk("beat_we", {31'd0, mem_we}, 32'd1);
            chk("beat_addr", mem_addr, a + 32'(k));
            chk("beat_data", {24'd0, mem_wdata}, (d >> (8 * (n - 1 - k))) & 32'hFF);
            chk("beat_busy_flags", {29'd0, busy, done, err}, 32'd4);
            chk("beat_lossy_hold", {31'd0, lossy}, {31'd0, last_lossy});
            mem_ready = rnd ? ($urandom_range(0, 2) != 0) : (k > 0 || st >= stalls);
            if (!mem_ready) st++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                size = 2'($urandom);
                addr = $urandom;
                data = $urandom;
            end
            if (mem_ready) k++;
            tick();
            cyc++;
            if (cyc > 64) begin
                total++;
                $display("FAIL timeout: no completion after %0d cycles, required %0d beats", cyc, n);
                break;
            end
        end
        start = 1'b0;
        mem_ready = 1'b1;
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_lossy", {31'd0, lossy}, {31'd0, exp_lossy});
        chk("done_idle", {29'd0, busy, mem_we, err}, 32'd0);
        chk("idle_addr", mem_addr, 32'd0);
        chk("idle_wdata", {24'd0, mem_wdata}, 32'd0);
        last_lossy = exp_lossy;
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a, d, x;
        int          r;
        tbl[0]  = '{2'b10, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 32'h0000_0203, 32'hFFFF_FF80, 0, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 32'h0000_0203, 32'h0000_0080, 0, 1'b0, 1'b1};
        tbl[3]  = '{2'b01, 32'h0000_0011, 32'h0000_1234, 0, 1'b1, 1'b0};
        tbl[4]  = '{2'b10, 32'h0000_0022, 32'h0000_1234, 0, 1'b1, 1'b0};
        tbl[5]  = '{2'b11, 32'h0000_0040, 32'h0000_1234, 0, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 32'h0000_0010, 32'h0000_1234, 2, 1'b0, 1'b0};
        tbl[7]  = '{2'b01, 32'h0000_0020, 32'h0000_8000, 0, 1'b0, 1'b1};
        tbl[8]  = '{2'b01, 32'h0000_0020, 32'hFFFF_8001, 1, 1'b0, 1'b0};
        tbl[9]  = '{2'b00, 32'h0000_0007, 32'h1234_5677, 0, 1'b0, 1'b1};
        tbl[10] = '{2'b10, 32'hFFFF_FFFC, 32'h0102_0304, 0, 1'b0, 1'b0};
        reset_n = 1'b0; start = 1'b0; size = 2'b00; addr = '0; data = '0; mem_ready = 1'b1;
        tick();
        tick();
        chk_zero("reset");
        reset_n = 1'b1;
        tick();
        foreach (tbl[i]) begin
            do_req(tbl[i].sz, tbl[i].a, tbl[i].d, tbl[i].stalls, 1'b0, 1'b0, tbl[i].exp_err, tbl[i].exp_lossy);
            tick();
        end
        // start during SEND is ignored; start in the done cycle is taken immediately
        do_req(2'b10, 32'h300, 32'hCAFE_F00D, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_req(2'b00, 32'h305, 32'h0000_017F, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        // reset in the middle of a word store
        size = 2'b10; addr = 32'h400; data = 32'h1122_3344; start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_beat0_addr", mem_addr, 32'h400);
        tick();
        chk("rst_beat1_addr", mem_addr, 32'h401);
        chk("rst_beat1_data", {24'd0, mem_wdata}, 32'h22);
        reset_n = 1'b0;
        tick();
        chk_zero("midreset");
        reset_n = 1'b1;
        tick();
        chk("midreset_no_done", {30'd0, done, mem_we}, 32'd0);
        last_lossy = 1'b0;
        do_req(2'b00, 32'h500, 32'h0000_0042, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (i == 5) begin sz = 2'b10; a = 32'hFFFF_FFFC; end
            x = $urandom;
            r = $urandom_range(0, 2);
            d = r == 0 ? $urandom : r == 1 ? {{24{x[7]}}, x[7:0]} : {{16{x[15]}}, x[15:0]};
            do_req(sz, a, d, 0, 1'b1, 1'($urandom_range(0, 1)), !m_legal(sz, a),
                   m_legal(sz, a) && m_lossy(sz, d));
            if ($urandom_range(0, 1) != 0) tick();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/store_narrower.md
# store_narrower

Store-side narrowing unit for the multi-cycle MIPS datapath: the inverse path of the 16→32 sign-extension used on immediates and loads. It takes a 32-bit register value plus a store size (SB/SH/SW). It then writes the selected low-order byte, halfword or word to a byte-wide data memory, one byte per accepted beat, in big-endian order. It rejects illegal or misaligned requests. It flags when narrowing discards information, i.e. when re-extending the stored value would not reproduce the register.

## Interface
- `ADDR_W`, 32, width of byte address.
- `SIGNED_CHK`, 1, lossy check mode: 1 = compare against sign-extension of stored part, 0 = against zero-extension.

- `clk`  input  1  rising-edge clock.
- `reset_n`  input  1  synchronous, active-low reset.
- `start`  input  1  request strobe, sampled only in IDLE.
- `size`  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `addr`  input  ADDR_W  byte address of the first (most significant) stored byte.
- `data`  input  32  register value to store.
- `busy`  output  1  high while a request is in SEND.
- `done`  output  1  one-cycle pulse after the last byte is accepted.
- `err`  output  1  one-cycle pulse for a rejected request.
- `lossy`  output  1  valid with `done`: narrowing lost bits.
- `mem_we`  output  1  byte write request.
- `mem_addr`  output  ADDR_W  byte address of the current beat.
- `mem_wdata`  output  8  byte of the current beat.
- `mem_ready`  input  1  memory accepts the beat when `mem_we && mem_ready`.

## Operation
- States: IDLE, SEND.
- In IDLE, when `start`=1, `addr`, `data` and `size` are sampled at the edge. The request is checked as follows.
  - Illegal: `size`=11; half with `addr[0]`=1; word with `addr[1:0]`≠00.
  - Illegal request: `err`=1 next cycle, no memory beat, stay IDLE.
  - Legal request: latch base address, data and beat count N (1/2/4), set index=0, go to SEND.
- In SEND:
  - `mem_we`=1, `mem_addr`=base+index.
  - `mem_wdata` is chosen big-endian:
    - byte: `data[7:0]`.
    - half: index 0 → `data[15:8]`, index 1 → `data[7:0]`.
    - word: index 0..3 → `data[31:24]`, `data[23:16]`, `data[15:8]`, `data[7:0]`.
- On each edge with `mem_ready`=1, index increments.
  - If the accepted beat was beat N−1: go to IDLE, `done`=1 for one cycle, `lossy` registered.
  - With `mem_ready`=0: hold all outputs unchanged (stall, unbounded).
- `lossy` rules:
  - byte: `data[31:8]` ≠ 24 copies of `data[7]` (`SIGNED_CHK`=1) or ≠0 (`SIGNED_CHK`=0).
  - half: same test with `data[31:16]` against `data[15]`.
  - word: always 0.
  - `lossy` holds its value until the next `done`.
- `start` while in SEND is ignored (no queueing); the latched request is unaffected by input changes.
- `start` in the cycle `done` or `err` is high is accepted normally (the block is in IDLE).
- `mem_addr` wraps modulo 2^ADDR_W (only reachable with a word at the top aligned address: no carry-out, no error).
- Whenever `mem_we`=0, `mem_addr` and `mem_wdata` are 0.

## Timing
- Reset values: all outputs 0 (`busy`, `done`, `err`, `lossy`, `mem_we`, `mem_addr`, `mem_wdata`); state IDLE.
- Reset mid-SEND: at the reset edge the transfer is abandoned. `mem_we`=0 from that cycle, no `done`, and partially written bytes are not rolled back.
- Start accepted at edge T, no stalls:
  - First beat is visible in cycle T+1.
  - `done` is high in cycle T+1+N: byte T+2, half T+3, word T+5.
  - Each `mem_ready`=0 cycle adds one cycle.
- `err` is high in cycle T+1 only.
- `busy` = (state==SEND) and is registered.
- `done` and `err` are never high in the same cycle.

## Test plan
- Reset then SW, `addr`=0x100, `data`=0xDEADBEEF, `mem_ready`=1 → beats (0x100,DE),(0x101,AD),(0x102,BE),(0x103,EF) in cycles T+1..T+4; `done` at T+5; `lossy`=0.
- SB `addr`=0x203, `data`=0xFFFFFF80, `SIGNED_CHK`=1 → single beat (0x203,80); `lossy`=0.
  - Repeat with `data`=0x00000080 → `lossy`=1.
- SH `addr`=0x10, `data`=0x00001234, `mem_ready` low for 2 cycles on beat 0 → (0x10,12) held 3 cycles, then (0x11,34); `done` at T+5; `lossy`=0.
- Rejects: SH `addr`=0x11; SW `addr`=0x22; `size`=11 → each `err` pulse at T+1, `mem_we` never high, `busy` stays 0.
- `start` pulsed during SEND with different data → ignored, original bytes written.
  - New `start` in the `done` cycle → accepted, first beat next cycle.
- `reset_n`=0 after beat 1 of an SW → `mem_we`=0 and all outputs 0 the next cycle; no `done`; a following SB completes normally.
